// File: rtl/bicubic_out_packer_if.sv
// Handshake bundle between the bicubic upsampler, the output packer
// and the access-control stage.
interface bicubic_out_packer_if #(
    parameter int CHANNEL_WIDTH = 8
);
    logic                       bcci_rsp_valid;
    logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1;
    logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data2;
    logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data3;
    logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data4;
    logic                       bf_rsp_ready;
    logic                       ac_req_valid;
    logic [4*CHANNEL_WIDTH-1:0] ac_req_data;
    logic                       ac_req_last;
    logic                       ac_req_user;
    logic                       ac_rsp_ready;

    modport master (
        output bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2,
        output bcci_rsp_data3, bcci_rsp_data4, ac_rsp_ready,
        input  bf_rsp_ready, ac_req_valid, ac_req_data,
        input  ac_req_last, ac_req_user
    );

    modport slave (
        input  bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2,
        input  bcci_rsp_data3, bcci_rsp_data4, ac_rsp_ready,
        output bf_rsp_ready, ac_req_valid, ac_req_data,
        output ac_req_last, ac_req_user
    );
endinterface

// File: rtl/bicubic_out_packer.sv
// Packs 4-pixel beats into tagged words behind a 2-entry skid FIFO.
// Optional frame_done pulse enabled by BCCI_PACK_FRAME_DONE_EN.
module bicubic_out_packer #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int BEATS_PER_ROW = 960,
    parameter int DST_ROWS      = 2160
) (
    input  logic clk,
    input  logic rst_n,
`ifdef BCCI_PACK_FRAME_DONE_EN
    output logic frame_done,
`endif
    bicubic_out_packer_if.slave bus
);
    localparam int DW = 4 * CHANNEL_WIDTH;
`ifdef BCCI_PACK_FRAME_DONE_EN
    localparam int EW = DW + 3;
`else
    localparam int EW = DW + 2;
`endif
    localparam int CW = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int RW = (DST_ROWS > 1) ? $clog2(DST_ROWS) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(BEATS_PER_ROW - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(DST_ROWS - 1);

    logic [EW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          in_hs;
    logic          out_hs;
    logic          tag_last;
    logic          tag_user;
    logic [DW-1:0] pix;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    // Ready comes from registered occupancy only, never from downstream
    assign bus.bf_rsp_ready = (count != 2'd2);
    assign bus.ac_req_valid = (count != 2'd0);
    assign in_hs  = bus.bcci_rsp_valid & bus.bf_rsp_ready;
    assign out_hs = bus.ac_req_valid & bus.ac_rsp_ready;

    assign tag_last = (col == COL_MAX);
    assign tag_user = (col == '0) & (row == '0);
    assign pix = {bus.bcci_rsp_data4, bus.bcci_rsp_data3,
                  bus.bcci_rsp_data2, bus.bcci_rsp_data1};

`ifdef BCCI_PACK_FRAME_DONE_EN
    assign wr_entry = {tag_last & (row == ROW_MAX), tag_user, tag_last, pix};
`else
    assign wr_entry = {tag_user, tag_last, pix};
`endif

    assign head = mem[rd_ptr];
    assign bus.ac_req_data = head[DW-1:0];
    assign bus.ac_req_last = head[DW];
    assign bus.ac_req_user = head[DW+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            col    <= '0;
            row    <= '0;
        end else begin
            if (in_hs) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
                if (tag_last) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (out_hs) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({in_hs, out_hs})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef BCCI_PACK_FRAME_DONE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_hs & head[DW+2];
        end
    end
`endif
endmodule

// File: tb/tb_bicubic_out_packer.sv
// Directed bench for bicubic_out_packer with a queue-based reference
// model checked every cycle plus literal spot checks.
module tb_bicubic_out_packer;
    localparam int CWD = 8;
    localparam int BPR = 4;
    localparam int ROWS = 2;
    localparam int FRAME = BPR * ROWS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef BCCI_PACK_FRAME_DONE_EN
    logic frame_done;
`endif

    bicubic_out_packer_if #(.CHANNEL_WIDTH(CWD)) bus ();

    bicubic_out_packer #(
        .CHANNEL_WIDTH(CWD),
        .BEATS_PER_ROW(BPR),
        .DST_ROWS(ROWS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef BCCI_PACK_FRAME_DONE_EN
        .frame_done(frame_done),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          n;
    } ent_t;

    ent_t q[$];
    int   n_beats = 0;
    int   checks = 0;
    int   errors = 0;
    int   fd_pulses = 0;
    logic fd_exp = 1'b0;
    bit   en = 1'b0;
    byte  seq = 8'h00;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: tags derived from beat index since reset
    always @(negedge clk) begin
        if (en) begin
            logic ih;
            logic oh;
            chk("ready", bus.bf_rsp_ready, q.size() < 2);
            chk("valid", bus.ac_req_valid, q.size() > 0);
            chk("occupancy", q.size() <= 2, 1);
            if (q.size() > 0) begin
                chk("data", bus.ac_req_data, q[0].d);
                chk("last", bus.ac_req_last, (q[0].n % BPR) == BPR - 1);
                chk("user", bus.ac_req_user, (q[0].n % FRAME) == 0);
            end
`ifdef BCCI_PACK_FRAME_DONE_EN
            chk("frame_done", frame_done, fd_exp);
            if (frame_done === 1'b1) fd_pulses++;
`endif
            if (!rst_n) begin
                q.delete();
                n_beats = 0;
                fd_exp = 1'b0;
            end else begin
                ih = bus.bcci_rsp_valid && (q.size() < 2);
                oh = (q.size() > 0) && bus.ac_rsp_ready;
                fd_exp = oh && ((q[0].n % FRAME) == FRAME - 1);
                if (oh) void'(q.pop_front());
                if (ih) begin
                    q.push_back('{d: {bus.bcci_rsp_data4, bus.bcci_rsp_data3,
                                      bus.bcci_rsp_data2, bus.bcci_rsp_data1},
                                  n: n_beats});
                    n_beats++;
                end
            end
        end
    end

    task automatic next_beat();
        seq = seq + 8'h01;
        bus.bcci_rsp_data1 = seq;
        bus.bcci_rsp_data2 = seq ^ 8'h5a;
        bus.bcci_rsp_data3 = seq + 8'h30;
        bus.bcci_rsp_data4 = ~seq;
    endtask

    task automatic drain(input string nm);
        bus.bcci_rsp_valid = 1'b0;
        bus.ac_rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ac_req_valid === 1'b0) break;
        end
        chk(nm, bus.ac_req_valid, 1'b0);
    endtask

    initial begin
        logic [8:0] last_tab;
        logic [8:0] user_tab;
        int ins;
        last_tab = 9'b010001000;
        user_tab = 9'b100000001;
        bus.bcci_rsp_valid = 1'b0;
        bus.ac_rsp_ready = 1'b1;
        bus.bcci_rsp_data1 = '0;
        bus.bcci_rsp_data2 = '0;
        bus.bcci_rsp_data3 = '0;
        bus.bcci_rsp_data4 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.bf_rsp_ready, 1'b1);
        chk("rst_valid", bus.ac_req_valid, 1'b0);
        chk("rst_data", bus.ac_req_data, 32'h0);
        chk("rst_last", bus.ac_req_last, 1'b0);
        chk("rst_user", bus.ac_req_user, 1'b0);

        // Single beat
        @(posedge clk);
        #1;
        bus.bcci_rsp_valid = 1'b1;
        bus.bcci_rsp_data1 = 8'h11;
        bus.bcci_rsp_data2 = 8'h22;
        bus.bcci_rsp_data3 = 8'h33;
        bus.bcci_rsp_data4 = 8'h44;
        @(posedge clk);
        #1 bus.bcci_rsp_valid = 1'b0;
        @(negedge clk);
        chk("single_valid", bus.ac_req_valid, 1'b1);
        chk("single_data", bus.ac_req_data, 32'h44332211);
        chk("single_user", bus.ac_req_user, 1'b1);
        chk("single_last", bus.ac_req_last, 1'b0);
        @(negedge clk);
        chk("single_pop", bus.ac_req_valid, 1'b0);

        // Fresh frame, stream 9 beats with ready high
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        fd_pulses = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            bus.bcci_rsp_valid = 1'b1;
            next_beat();
            if (k > 0) begin
                @(negedge clk);
                chk("stream_last", bus.ac_req_last, last_tab[k-1]);
                chk("stream_user", bus.ac_req_user, user_tab[k-1]);
            end
        end
        @(posedge clk);
        #1 bus.bcci_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stream_last8", bus.ac_req_last, last_tab[8]);
        chk("stream_user8", bus.ac_req_user, user_tab[8]);
        drain("stream_drain");
        repeat (2) @(negedge clk);
`ifdef BCCI_PACK_FRAME_DONE_EN
        chk("fd_pulses", fd_pulses, 1);
`endif

        // Backpressure: exactly two beats accepted
        @(posedge clk);
        #1;
        bus.ac_rsp_ready = 1'b0;
        bus.bcci_rsp_valid = 1'b1;
        next_beat();
        ins = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.bf_rsp_ready === 1'b1) ins++;
            @(posedge clk);
            #1 next_beat();
        end
        @(negedge clk);
        chk("bp_ins", ins, 2);
        chk("bp_ready", bus.bf_rsp_ready, 1'b0);
        drain("bp_drain");

        // Alternating downstream ready
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.ac_rsp_ready = (i % 2 == 0);
            bus.bcci_rsp_valid = 1'b1;
            next_beat();
        end
        @(posedge clk);
        #1 drain("alt_drain");

        // Partial row, fill FIFO, then reset
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            bus.ac_rsp_ready = 1'b1;
            bus.bcci_rsp_valid = 1'b1;
            next_beat();
        end
        @(posedge clk);
        #1;
        bus.ac_rsp_ready = 1'b0;
        next_beat();
        repeat (3) @(posedge clk);
        #1;
        bus.bcci_rsp_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_valid", bus.ac_req_valid, 1'b0);
        chk("mrst_ready", bus.bf_rsp_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.ac_rsp_ready = 1'b1;
        bus.bcci_rsp_valid = 1'b1;
        next_beat();
        @(posedge clk);
        #1 next_beat();
        @(negedge clk);
        chk("mrst_user", bus.ac_req_user, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 next_beat();
        end
        @(posedge clk);
        #1 drain("mrst_drain");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bicubic_out_packer.md
# bicubic_out_packer

Downstream stage of the bicubic upsampler. Each handshake accepts one beat of four horizontally adjacent output pixels from the upsampler. It packs them into one word and tags each word with end-of-row and start-of-frame markers. Words are delivered to the access-control stage through a 2-entry skid FIFO, so the upsampler pipeline is never stalled combinationally by the downstream ready.

## Interface
Parameters:
- CHANNEL_WIDTH, 8, bits per pixel channel
- BEATS_PER_ROW, 960, input beats per output row (4 pixels each)
- DST_ROWS, 2160, output rows per frame

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset: one clock, synchronous, active-low; all state is cleared on the rising edge of clk while rst_n=0
- bcci_rsp_valid  in  1  upsampler beat valid
- bcci_rsp_data1..4  in  CHANNEL_WIDTH each  pixels, data1 leftmost
- bf_rsp_ready  out  1  ready to upsampler
- ac_req_valid  out  1  packed word valid
- ac_req_data  out  4*CHANNEL_WIDTH  {data4,data3,data2,data1}; data1 in [CHANNEL_WIDTH-1:0]
- ac_req_last  out  1  word is last of its output row
- ac_req_user  out  1  word is first of the frame
- ac_rsp_ready  in  1  access-control ready

## Operation
- Input handshake: in_hs = bcci_rsp_valid & bf_rsp_ready. Output handshake: out_hs = ac_req_valid & ac_rsp_ready.
- FIFO: 2 entries. Each entry holds {user, last, data} (4*CHANNEL_WIDTH+2 bits). Write pointer, read pointer and 2-bit occupancy count are registered.
- bf_rsp_ready = (count != 2), taken from registered count only; it never depends on ac_rsp_ready.
- ac_req_valid = (count != 0). Outputs present the head entry.
- Column counter col (0..BEATS_PER_ROW-1) advances on in_hs:
  - at BEATS_PER_ROW-1 it wraps to 0;
  - on that wrap the row counter row (0..DST_ROWS-1) advances, wrapping to 0 after DST_ROWS-1.
- Tags are computed at write time from the pre-increment counters:
  - last = (col == BEATS_PER_ROW-1);
  - user = (col == 0) & (row == 0).
- Count update: +1 on in_hs only, -1 on out_hs only, unchanged on both or neither.
- Simultaneous in_hs and out_hs with count=1: the new entry is written while the head is popped; count stays 1; order is preserved.
- At count=2, in_hs cannot occur. out_hs frees a slot, and bf_rsp_ready rises the following cycle.
- Pointers are 1 bit and wrap naturally.
- Input data is never modified: no saturation and no rounding; this stage only packs.

## Timing
- Reset values:
  - bf_rsp_ready=1 (count=0);
  - ac_req_valid=0;
  - ac_req_data=0, ac_req_last=0, ac_req_user=0 (FIFO storage cleared);
  - col=0, row=0, both pointers 0.
- Latency: in_hs in cycle N gives ac_req_valid=1 with that word at cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle when ac_rsp_ready is held high.
- Backpressure:
  - with ac_rsp_ready=0, at most 2 words are accepted, then bf_rsp_ready=0 from the cycle after the second in_hs;
  - ac_req_* stay stable while ac_req_valid=1 and ac_rsp_ready=0.
- Reset asserted mid-frame: the next cycle shows the reset values; buffered words are discarded. The first beat after reset carries user=1.
- Frame wrap: the beat after the last beat of row DST_ROWS-1 carries user=1 again.

## Configuration
- BCCI_PACK_FRAME_DONE_EN
  - Defined: adds output frame_done (1 bit, reset 0). It pulses high for exactly one cycle, in the cycle after the out_hs of the word with last=1 in row DST_ROWS-1.
  - Tracking that word needs a 1-bit "end-of-frame" tag stored per FIFO entry.
  - Undefined: the port, the extra tag bit and the related logic are absent; all other behaviour is identical.

## Test plan
- Reset then a single beat with data1..4=0x11,0x22,0x33,0x44 and ac_rsp_ready=1:
  - next cycle shows ac_req_valid=1, ac_req_data=0x44332211, user=1, last=0;
  - valid drops after out_hs.
- Stream BEATS_PER_ROW=4, DST_ROWS=2 with ready high: last=1 exactly on beats 3 and 7; user=1 on beats 0 and 8.
- Hold ac_rsp_ready=0 and drive valid continuously: exactly 2 in_hs occur and bf_rsp_ready=0 from then on. After ready=1, words emerge in order, with no loss or duplication.
- Pattern ac_rsp_ready=1,0,1,0…:
  - every input word appears exactly once and in order;
  - output fields are stable during stalls;
  - count never exceeds 2.
- Assert rst_n=0 for one cycle mid-row with 2 words buffered:
  - next cycle ac_req_valid=0 and bf_rsp_ready=1;
  - next beat has user=1 and the column restarts at 0.
- With BCCI_PACK_FRAME_DONE_EN and a 4x2 frame: frame_done=1 for one cycle, one cycle after the 8th out_hs; 0 at all other times.
